// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: mode encodings, FSM states
// and the effective shift-count helper.
package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Linear shifts saturate at the data width; rotates wrap modulo the width.
    function automatic logic [31:0] eff_count(input logic [63:0] amt,
                                              input logic [2:0]  mode,
                                              input int unsigned w);
        logic [31:0] n;
        n = '0;
        case (mode)
            MODE_SLL, MODE_SRL, MODE_SRA: n = (amt > 64'(w)) ? w : amt[31:0];
            MODE_ROL, MODE_ROR:           n = 32'(amt % 64'(w));
            default:                      n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts or rotates by k (0..ST) positions.
module shift_step
    import shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int ST = 4,
    parameter int KW = $clog2(ST + 1)
) (
    input  logic [W-1:0]  data,
    input  logic [KW-1:0] k,
    input  logic [2:0]    mode,
    output logic [W-1:0]  res
);

    logic [ST:0][W-1:0] cand;

    // One candidate per constant step size; the runtime k just selects one.
    for (genvar gi = 0; gi <= ST; gi++) begin : g_cand
        logic [W-1:0] c;
        always_comb begin
            c = data;
            case (mode)
                MODE_SLL: c = data << gi;
                MODE_SRL: c = data >> gi;
                MODE_SRA: c = $signed(data) >>> gi;
                MODE_ROL: c = (data << gi) | (data >> (W - gi));
                MODE_ROR: c = (data >> gi) | (data << (W - gi));
                default:  c = data;
            endcase
        end
        assign cand[gi] = c;
    end

    always_comb begin
        res = data;
        if (k <= KW'(ST)) begin
            res = cand[k];
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter/rotator with valid/ready handshakes; moves at most ST
// bit positions per cycle and holds the result until the consumer takes it.
module shift_unit
    import shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = 8,
    parameter int ST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [SW-1:0] in_amt,
    input  logic [2:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_err,
    output logic          busy
);

    localparam int CW = $clog2(W + 1);
    localparam int KW = $clog2(ST + 1);

    state_t        state_reg;
    logic [W-1:0]  work_reg;
    logic [2:0]    mode_reg;
    logic [CW-1:0] n_rem_reg;
    logic          err_reg;

    logic [CW-1:0] n_acc;
    logic          mode_ok;
    logic [CW-1:0] k_sel;
    logic [W-1:0]  step_res;

    assign mode_ok = (in_mode <= MODE_ROR);
    assign n_acc   = CW'(eff_count(64'(in_amt), in_mode, W));
    assign k_sel   = (n_rem_reg > CW'(ST)) ? CW'(ST) : n_rem_reg;

    shift_step #(
        .W  (W),
        .ST (ST),
        .KW (KW)
    ) u_step (
        .data (work_reg),
        .k    (KW'(k_sel)),
        .mode (mode_reg),
        .res  (step_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            work_reg  <= '0;
            mode_reg  <= '0;
            n_rem_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_reg <= in_data;
                        mode_reg <= in_mode;
                        err_reg  <= !mode_ok;
                        if (mode_ok && (n_acc != '0)) begin
                            n_rem_reg <= n_acc;
                            state_reg <= ST_SHIFT;
                        end else begin
                            n_rem_reg <= '0;
                            state_reg <= ST_HOLD;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg  <= step_res;
                    n_rem_reg <= n_rem_reg - k_sel;
                    if (n_rem_reg == k_sel) begin
                        state_reg <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_HOLD);
    assign busy      = (state_reg != ST_IDLE);
    assign out_data  = work_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: the driver queues expected results, a
// negedge monitor pops and compares whenever a result is presented.
module tb_shift_unit;

    localparam int W  = 8;
    localparam int SW = 8;
    localparam int ST = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_amt;
    logic [2:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic          busy;

    shift_unit #(.W(W), .SW(SW), .ST(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         t;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [7:0] a;
        logic [2:0] m;
        logic [7:0] x;
        logic       e;
        int         n;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first HOLD cycle checks value/flag/latency, later cycles check stability.
    logic       holding = 1'b0;
    logic [7:0] held_data;
    logic       held_err;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else if (out_valid) begin
            if (!holding) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got out_data 0x%0h, expected no result", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_err", 32'(out_err), 32'(mon_e.err));
                    check("latency", 32'(cyc - mon_e.t), 32'(mon_e.lat));
                    $display("result data=0x%0h err=%0b latency=%0d", out_data, out_err, cyc - mon_e.t);
                end
                holding   = 1'b1;
                held_data = out_data;
                held_err  = out_err;
            end else begin
                check("hold_data", 32'(out_data), 32'(held_data));
                check("hold_err", 32'(out_err), 32'(held_err));
            end
            if (out_ready) holding = 1'b0;
        end
    end

    // Called at posedge+1; the request is accepted at the next edge.
    task automatic issue(input vec_t v);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            check("issue_timeout_in_ready", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = v.d;
        in_amt   = v.a;
        in_mode  = v.m;
        sb.push_back('{data: v.x, err: v.e, t: cyc, lat: 1 + (v.n + ST - 1) / ST});
        $display("issue data=0x%0h amt=%0d mode=%0d expect=0x%0h err=%0b", v.d, v.a, v.m, v.x, v.e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_amt   = 8'($urandom);
        in_mode  = 3'($urandom);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while ((sb.size() != 0 || !in_ready) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) check("done_timeout_pending", 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[] = '{
        '{d: 8'h81, a: 8'd3,   m: 3'd0, x: 8'h08, e: 1'b0, n: 3},
        '{d: 8'h90, a: 8'd9,   m: 3'd2, x: 8'hFF, e: 1'b0, n: 8},
        '{d: 8'h01, a: 8'd9,   m: 3'd4, x: 8'h80, e: 1'b0, n: 1},
        '{d: 8'hB4, a: 8'd8,   m: 3'd3, x: 8'hB4, e: 1'b0, n: 0},
        '{d: 8'h5A, a: 8'd3,   m: 3'd6, x: 8'h5A, e: 1'b1, n: 0},
        '{d: 8'hFF, a: 8'd8,   m: 3'd0, x: 8'h00, e: 1'b0, n: 8},
        '{d: 8'h40, a: 8'd7,   m: 3'd2, x: 8'h00, e: 1'b0, n: 7},
        '{d: 8'h81, a: 8'd5,   m: 3'd3, x: 8'h30, e: 1'b0, n: 5},
        '{d: 8'hA5, a: 8'd2,   m: 3'd2, x: 8'hE9, e: 1'b0, n: 2},
        '{d: 8'h5A, a: 8'd0,   m: 3'd0, x: 8'h5A, e: 1'b0, n: 0},
        '{d: 8'h33, a: 8'd3,   m: 3'd5, x: 8'h33, e: 1'b1, n: 0},
        '{d: 8'hC3, a: 8'd12,  m: 3'd4, x: 8'h3C, e: 1'b0, n: 4},
        '{d: 8'h80, a: 8'd200, m: 3'd1, x: 8'h00, e: 1'b0, n: 8},
        '{d: 8'h01, a: 8'd7,   m: 3'd3, x: 8'h80, e: 1'b0, n: 7}
    };

    initial begin
        int g;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // First request right after reset release, then the rest back to back.
        foreach (vecs[i]) begin
            issue(vecs[i]);
            wait_done();
        end

        // Backpressure: result must hold while junk requests are offered.
        out_ready = 1'b0;
        issue('{d: 8'hF0, a: 8'd4, m: 3'd1, x: 8'h0F, e: 1'b0, n: 4});
        g = 0;
        while (!out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_data  = 8'hAA;
            in_amt   = 8'd1;
            in_mode  = 3'd0;
            @(posedge clk); #1;
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset during SHIFT aborts the operation without a result.
        issue('{d: 8'h90, a: 8'd9, m: 3'd2, x: 8'hFF, e: 1'b0, n: 8});
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle_out_valid", 32'(out_valid), 32'd0);
        issue('{d: 8'h90, a: 8'd9, m: 3'd2, x: 8'hFF, e: 1'b0, n: 8});
        wait_done();
        issue('{d: 8'h81, a: 8'd3, m: 3'd0, x: 8'h08, e: 1'b0, n: 3});
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning data width in bits, with W >= 2.
REQ-002 The module SHALL have parameter SW, default 8, meaning shift-amount width in bits.
REQ-003 The module SHALL have parameter ST, default 4, meaning maximum bit positions shifted per cycle, as a power of 2 with 1 <= ST <= W.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock, rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-006 Port in_valid SHALL be an input, 1 bit wide: the request is valid.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the unit accepts a request.
REQ-008 Port in_data SHALL be an input, W bits wide: the operand.
REQ-009 Port in_amt SHALL be an input, SW bits wide: the unsigned shift amount.
REQ-010 Port in_mode SHALL be an input, 3 bits wide: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 reserved.
REQ-011 Port out_valid SHALL be an output, 1 bit wide: the result is valid.
REQ-012 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-013 Port out_data SHALL be an output, W bits wide: the result.
REQ-014 Port out_err SHALL be an output, 1 bit wide: the result came from a reserved mode.
REQ-015 Port busy SHALL be an output, 1 bit wide: the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE, and an accept SHALL occur when in_valid=1 and in_ready=1.
REQ-018 On accept, the unit SHALL register in_data, in_mode and the effective count n, where n = min(in_amt, W) for SLL/SRL/SRA and n = in_amt mod W for ROL/ROR.
REQ-019 On accept, the next state SHALL be SHIFT if n > 0 and the mode is valid, otherwise HOLD.
REQ-020 Each SHIFT cycle SHALL shift the working register by k = min(n_rem, ST) in the registered mode and set n_rem = n_rem - k.
REQ-021 When n_rem reaches 0, the state SHALL go to HOLD.
REQ-022 Fill rules: SLL fills zeros at the LSBs; SRL fills zeros at the MSBs; SRA replicates the operand MSB; ROL/ROR wrap the bits.
REQ-023 For n = W, SLL/SRL SHALL yield 0 and SRA SHALL yield all bits equal to the operand MSB.
REQ-024 Latency: for an accept at edge t, out_valid SHALL rise after edge t+1+ceil(n/ST); for n = 0 this is after edge t+1.
REQ-025 In HOLD, out_valid SHALL be 1, and out_data and out_err SHALL stay stable until out_ready=1, after which the next state is IDLE.
REQ-026 out_valid=1 with out_ready=1 SHALL complete the transfer in that cycle, with no new accept in the same cycle because in_ready=0.
REQ-027 The sustained rate SHALL be at most one operation per 2+ceil(n/ST) cycles.
REQ-028 in_valid, in_data, in_amt and in_mode SHALL be ignored outside IDLE, and registered operands SHALL not change mid-operation.
REQ-029 For a reserved mode, the unit SHALL go directly to HOLD with out_data equal to the operand and out_err=1.
REQ-030 For a valid mode, out_err SHALL be 0.
REQ-031 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-032 While rst_n=0, the unit SHALL hold state IDLE with out_valid=0, out_data=0, out_err=0, busy=0, in_ready=1, and all working registers at 0.
REQ-033 Reset asserted in SHIFT or HOLD SHALL abort the operation with no result delivered.
REQ-034 The first accept after rst_n rises SHALL be possible on the first clk edge.

Structure
REQ-035 Package shift_pkg SHALL hold the mode encoding constants (MODE_SLL through MODE_ROR), the FSM state typedef, and a function returning the effective count.
REQ-036 One combinational sub-module, shift_step, SHALL perform a single shift of k (0..ST) positions in a given mode, instantiated once in shift_unit.
REQ-037 No multi-cycle datapath outside the working register, n_rem and the FSM SHALL exist.

Verification (W=8, SW=8, ST=4)
REQ-038 SLL 0x81 by 3, out_ready=1 -> out_data=0x08, out_err=0, out_valid after edge t+2, one SHIFT cycle.
REQ-039 SRA 0x90 by 9 -> n=8, two SHIFT cycles, out_data=0xFF, out_valid after edge t+3.
REQ-040 ROR 0x01 by 9 -> n=1, out_data=0x80.
REQ-041 ROL 0xB4 by 8 -> n=0, out_data=0xB4, out_valid after edge t+1.
REQ-042 Backpressure: SRL 0xF0 by 4 with out_ready=0 for 5 cycles -> out_data=0x0F held stable, busy=1, in_valid pulses ignored; after out_ready=1, IDLE with in_ready=1.
REQ-043 Mode 6 on 0x5A -> out_data=0x5A, out_err=1.
REQ-044 rst_n low during SHIFT -> out_valid stays 0, and the next request returns the correct result.
